// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
// Operand format: sign [31], exponent [30:25], mantissa [24:0].
package fp_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } sched_state_t;

   localparam logic [3:0] ST_EXACT     = 4'd0;
   localparam logic [3:0] ST_OVERFLOW  = 4'd1;
   localparam logic [3:0] ST_UNDERFLOW = 4'd2;
   localparam logic [3:0] ST_INEXACT   = 4'd3;
   localparam logic [3:0] ST_TIMEOUT   = 4'd8;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 25;
   localparam int MAN_MSB  = 24;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps.
// The pointer itself is owned by the caller.
module fp_rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int IW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx,
   output logic             any
);

   logic [IW-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % N_REQ);
         if (!any && valid[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one floating-point adder among N_REQ requesters: round-robin accept,
// single-cycle issue, watchdog-bounded wait, then a held response to the owner.
module fp_add_scheduler
   import fp_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64,
   localparam int IW = $clog2(N_REQ)
) (
   input  logic                  clock_100kHz,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*32-1:0]   req_op_a,
   input  logic [N_REQ*32-1:0]   req_op_b,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [3:0]            rsp_status,
   output logic                  fpu_start,
   output logic [31:0]           fpu_op_a,
   output logic [31:0]           fpu_op_b,
   input  logic                  fpu_done,
   input  logic [31:0]           fpu_data,
   input  logic [3:0]            fpu_status,
   output logic                  busy,
   output logic [IW-1:0]         grant_id,
   output sched_state_t          state
);

   // Handshakes: a transfer happens on the rising edge where valid and ready
   // are both high; ready never waits on anything but state and the arbiter,
   // and rsp_valid/rsp_data/rsp_status stay frozen until the owner's rsp_ready.

   sched_state_t     next_state;
   logic [IW-1:0]    ptr;
   logic [7:0]       cnt;
   logic [N_REQ-1:0] win;
   logic [IW-1:0]    win_idx;
   logic             win_any;
   logic             timeout_hit;
   logic             rsp_taken;

   fp_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .valid     (req_valid),
      .ptr       (ptr),
      .grant     (win),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
   assign rsp_taken   = rsp_ready[grant_id];

   always_comb begin
      next_state = state;
      req_ready  = '0;
      rsp_valid  = '0;
      fpu_start  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = win;
            if (win_any) next_state = ISSUE;
         end
         ISSUE: begin
            fpu_start  = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            if (fpu_done || timeout_hit) next_state = RESPOND;
         end
         RESPOND: begin
            rsp_valid[grant_id] = 1'b1;
            if (rsp_taken) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock_100kHz or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= IW'(N_REQ - 1);
         cnt        <= '0;
         grant_id   <= '0;
         fpu_op_a   <= '0;
         fpu_op_b   <= '0;
         rsp_data   <= '0;
         rsp_status <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (win_any) begin
                  fpu_op_a <= req_op_a[int'(win_idx)*32 +: 32];
                  fpu_op_b <= req_op_b[int'(win_idx)*32 +: 32];
                  grant_id <= win_idx;
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               // A done arriving on the watchdog's last cycle still reports real data.
               if (fpu_done) begin
                  rsp_data   <= fpu_data;
                  rsp_status <= fpu_status;
               end else if (timeout_hit) begin
                  rsp_data   <= '0;
                  rsp_status <= ST_TIMEOUT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESPOND: begin
               if (rsp_taken) ptr <= grant_id;
            end
            default: ;
         endcase
      end
   end

endmodule
